disp_ctrl: RTL and testbench

Display sequencing controller that owns the sync generator's control inputs (RESOL, VRSTART, its active-high reset) and schedules per-line frame-buffer fetches.
- Starts and stops display on a register enable.
- Applies resolution changes only at frame boundaries.
- Issues one line-fetch request per active line to the VRAM read engine via req/ack handshake.
- Sits between the control register block and syncgen / VRAM reader.

---
 rtl/disp_ctrl_pkg.sv | 36 +++
 rtl/disp_fetch_sched.sv | 100 ++++++++++
 rtl/disp_ctrl.sv | 117 +++++++++++
 tb/tb_disp_ctrl.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/disp_ctrl_pkg.sv
// rtl/disp_ctrl_pkg.sv - shared resolution codes, active-line table and state encoding for disp_ctrl
package disp_ctrl_pkg;

    localparam int LINE_W = 11;

    localparam logic [1:0] RES_VGA  = 2'b00;
    localparam logic [1:0] RES_SVGA = 2'b01;
    localparam logic [1:0] RES_XGA  = 2'b10;
    localparam logic [1:0] RES_SXGA = 2'b11;

    // Active (fetched) lines per frame, shared with the sync generator timing set.
    localparam logic [LINE_W-1:0] VDO_VGA  = 11'd480;
    localparam logic [LINE_W-1:0] VDO_SVGA = 11'd600;
    localparam logic [LINE_W-1:0] VDO_XGA  = 11'd768;
    localparam logic [LINE_W-1:0] VDO_SXGA = 11'd1024;

    typedef enum logic [3:0] {
        S_OFF   = 4'b0001,
        S_RST   = 4'b0010,
        S_START = 4'b0100,
        S_RUN   = 4'b1000
    } disp_state_e;

    function automatic logic [LINE_W-1:0] vdo_lines(input logic [1:0] resol);
        logic [LINE_W-1:0] v;
        v = VDO_VGA;
        case (resol)
            RES_VGA:  v = VDO_VGA;
            RES_SVGA: v = VDO_SVGA;
            RES_XGA:  v = VDO_XGA;
            RES_SXGA: v = VDO_SXGA;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/disp_fetch_sched.sv
// rtl/disp_fetch_sched.sv - sync edge detection, active-line counter and line-fetch req/ack scheduling
module disp_fetch_sched
    import disp_ctrl_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              run_i,
    input  logic              clr_i,
    input  logic [1:0]        resol_i,
    input  logic              vsync_n_i,
    input  logic              pre_de_i,
    input  logic              ack_i,
    output logic              vs_fall_o,
    output logic              req_o,
    output logic [LINE_W-1:0] line_o,
    output logic              underrun_o
);

    logic              vs_d_q, de_d_q;
    logic              vs_fall_q, vs_rise_q, de_fall_q;
    logic              vs_fall, vs_rise, de_fall;
    logic [LINE_W-1:0] cnt_q, cnt_d;
    logic [LINE_W-1:0] line_q, line_d;
    logic              req_q, req_d;
    logic              under_q, under_d;
    logic              trig;
    logic [LINE_W-1:0] trig_line;
    logic [LINE_W-1:0] last_line;

    assign vs_fall   = vs_d_q & ~vsync_n_i;
    assign vs_rise   = ~vs_d_q & vsync_n_i;
    assign de_fall   = de_d_q & ~pre_de_i;
    assign last_line = vdo_lines(resol_i) - 11'd1;

    // Edge pulses are registered once more so triggers act two clocks after the input edge.
    always_comb begin
        trig      = 1'b0;
        trig_line = '0;
        if (vs_rise_q) begin
            trig      = 1'b1;
            trig_line = '0;
        end else if (de_fall_q && (cnt_q < last_line)) begin
            trig      = 1'b1;
            trig_line = cnt_q + 11'd1;
        end
    end

    always_comb begin
        req_d   = req_q;
        line_d  = line_q;
        cnt_d   = cnt_q;
        under_d = under_q;
        if (clr_i) begin
            under_d = 1'b0;
        end
        if (!run_i) begin
            req_d = 1'b0;
        end else if (trig) begin
            cnt_d = trig_line;
            if (!req_q || ack_i) begin
                req_d  = 1'b1;
                line_d = trig_line;
            end else begin
                under_d = 1'b1;
            end
        end else if (ack_i) begin
            req_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            vs_d_q    <= 1'b1;
            de_d_q    <= 1'b0;
            vs_fall_q <= 1'b0;
            vs_rise_q <= 1'b0;
            de_fall_q <= 1'b0;
            cnt_q     <= '0;
            line_q    <= '0;
            req_q     <= 1'b0;
            under_q   <= 1'b0;
        end else begin
            vs_d_q    <= vsync_n_i;
            de_d_q    <= pre_de_i;
            vs_fall_q <= vs_fall;
            vs_rise_q <= vs_rise;
            de_fall_q <= de_fall;
            cnt_q     <= cnt_d;
            line_q    <= line_d;
            req_q     <= req_d;
            under_q   <= under_d;
        end
    end

    assign vs_fall_o  = vs_fall_q;
    assign req_o      = req_q;
    assign line_o     = line_q;
    assign underrun_o = under_q;

endmodule

// File: rtl/disp_ctrl.sv
// rtl/disp_ctrl.sv - display sequencing controller: syncgen reset/start, frame-boundary resolution changes
module disp_ctrl
    import disp_ctrl_pkg::*;
#(
    parameter int RST_CYC = 4,
    parameter int FCNT_W  = 16
) (
    input  logic              DCLK,
    input  logic              DRST_X,
    input  logic              DISPON,
    input  logic [1:0]        RESOL_IN,
    input  logic              DSP_VSYNC_X,
    input  logic              DSP_preDE,
    input  logic              FETCH_ACK,
    output logic [1:0]        RESOL,
    output logic              SG_RST,
    output logic              VRSTART,
    output logic              FETCH_REQ,
    output logic [LINE_W-1:0] FETCH_LINE,
    output logic [FCNT_W-1:0] FRAME_CNT,
    output logic              UNDERRUN,
    output logic              BUSY
);

    disp_state_e       state_q, state_d;
    logic [3:0]        rcnt_q, rcnt_d;
    logic [1:0]        resol_q, resol_d;
    logic [FCNT_W-1:0] fcnt_q, fcnt_d;
    logic              sg_rst_q, vrstart_q;
    logic              enter_rst;
    logic              vs_fall;

    always_comb begin
        state_d   = state_q;
        rcnt_d    = rcnt_q;
        resol_d   = resol_q;
        fcnt_d    = fcnt_q;
        enter_rst = 1'b0;
        case (state_q)
            S_OFF: begin
                if (DISPON) begin
                    state_d   = S_RST;
                    enter_rst = 1'b1;
                end
            end
            S_RST: begin
                if (!DISPON) begin
                    state_d = S_OFF;
                end else if (rcnt_q == 4'd0) begin
                    state_d = S_START;
                end else begin
                    rcnt_d = rcnt_q - 4'd1;
                end
            end
            S_START: state_d = S_RUN;
            S_RUN: begin
                // Enable and resolution are only acted on at the frame boundary.
                if (vs_fall) begin
                    fcnt_d = fcnt_q + FCNT_W'(1);
                    if (!DISPON) begin
                        state_d = S_OFF;
                    end else if (RESOL_IN != resol_q) begin
                        state_d   = S_RST;
                        enter_rst = 1'b1;
                    end
                end
            end
            default: state_d = S_OFF;
        endcase
        if (enter_rst) begin
            resol_d = RESOL_IN;
            fcnt_d  = '0;
            rcnt_d  = 4'(RST_CYC - 1);
        end
    end

    // Syncgen controls are registered from the current state and trail it by one clock.
    always_ff @(posedge DCLK) begin
        if (!DRST_X) begin
            state_q   <= S_OFF;
            rcnt_q    <= '0;
            resol_q   <= RES_VGA;
            fcnt_q    <= '0;
            sg_rst_q  <= 1'b1;
            vrstart_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            rcnt_q    <= rcnt_d;
            resol_q   <= resol_d;
            fcnt_q    <= fcnt_d;
            sg_rst_q  <= (state_q == S_OFF) || (state_q == S_RST);
            vrstart_q <= (state_q == S_START);
        end
    end

    disp_fetch_sched u_fetch (
        .clk_i      (DCLK),
        .rst_n_i    (DRST_X),
        .run_i      (state_q == S_RUN),
        .clr_i      (enter_rst),
        .resol_i    (resol_q),
        .vsync_n_i  (DSP_VSYNC_X),
        .pre_de_i   (DSP_preDE),
        .ack_i      (FETCH_ACK),
        .vs_fall_o  (vs_fall),
        .req_o      (FETCH_REQ),
        .line_o     (FETCH_LINE),
        .underrun_o (UNDERRUN)
    );

    assign RESOL     = resol_q;
    assign SG_RST    = sg_rst_q;
    assign VRSTART   = vrstart_q;
    assign FRAME_CNT = fcnt_q;
    assign BUSY      = (state_q != S_OFF);

endmodule

// File: tb/tb_disp_ctrl.sv
// tb/tb_disp_ctrl.sv - self-checking bench for disp_ctrl with randomized line timing and ack delays
module tb_disp_ctrl;

    localparam int RST_CYC = 4;
    localparam int FCNT_W  = 4;

    logic              DCLK        = 1'b0;
    logic              DRST_X      = 1'b0;
    logic              DISPON      = 1'b0;
    logic [1:0]        RESOL_IN    = 2'b00;
    logic              DSP_VSYNC_X = 1'b1;
    logic              DSP_preDE   = 1'b0;
    logic              FETCH_ACK;
    logic [1:0]        RESOL;
    logic              SG_RST;
    logic              VRSTART;
    logic              FETCH_REQ;
    logic [10:0]       FETCH_LINE;
    logic [FCNT_W-1:0] FRAME_CNT;
    logic              UNDERRUN;
    logic              BUSY;

    int          checks   = 0;
    int          failures = 0;
    logic        ack_en   = 1'b0;
    logic        ack_man  = 1'b0;
    logic        ack_auto = 1'b0;
    int          ack_cnt  = 0;
    int          ack_dly  = 3;
    logic [10:0] got[$];

    assign FETCH_ACK = ack_en ? ack_auto : ack_man;

    always #5 DCLK = ~DCLK;

    disp_ctrl #(.RST_CYC(RST_CYC), .FCNT_W(FCNT_W)) dut (
        .DCLK        (DCLK),
        .DRST_X      (DRST_X),
        .DISPON      (DISPON),
        .RESOL_IN    (RESOL_IN),
        .DSP_VSYNC_X (DSP_VSYNC_X),
        .DSP_preDE   (DSP_preDE),
        .FETCH_ACK   (FETCH_ACK),
        .RESOL       (RESOL),
        .SG_RST      (SG_RST),
        .VRSTART     (VRSTART),
        .FETCH_REQ   (FETCH_REQ),
        .FETCH_LINE  (FETCH_LINE),
        .FRAME_CNT   (FRAME_CNT),
        .UNDERRUN    (UNDERRUN),
        .BUSY        (BUSY)
    );

    // VRAM reader stand-in: acks each request 1..3 cycles after it appears.
    always @(posedge DCLK) begin
        #1;
        if (!ack_en || ack_auto) begin
            ack_auto = 1'b0;
            ack_cnt  = 0;
        end else if (FETCH_REQ) begin
            ack_cnt = ack_cnt + 1;
            if (ack_cnt >= ack_dly) begin
                ack_auto = 1'b1;
                ack_dly  = $urandom_range(1, 3);
            end
        end
    end

    always @(negedge DCLK) begin
        if (FETCH_REQ && FETCH_ACK) got.push_back(FETCH_LINE);
    end

    function automatic int vdo(input logic [1:0] r);
        return (r == 2'd0) ? 480 : (r == 2'd1) ? 600 : (r == 2'd2) ? 768 : 1024;
    endfunction

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge DCLK);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic vsync_pulse();
        DSP_VSYNC_X = 1'b0;
        tick($urandom_range(2, 4));
        DSP_VSYNC_X = 1'b1;
        tick($urandom_range(4, 7));
    endtask

    task automatic lines(input int n);
        for (int i = 0; i < n; i++) begin
            DSP_preDE = 1'b1;
            tick($urandom_range(1, 3));
            DSP_preDE = 1'b0;
            tick($urandom_range(6, 8));
        end
    endtask

    // A frame with n preDE pulses yields line 0 on vsync rise plus one line per pulse, capped at VDO.
    task automatic check_frame(input string tag, input int n, input logic [1:0] r);
        int exp_n;
        int nbad;
        exp_n = (n + 1 < vdo(r)) ? n + 1 : vdo(r);
        nbad  = 0;
        foreach (got[i]) if (int'(got[i]) != i) nbad++;
        chk({tag, "_count"}, got.size(), exp_n);
        chk({tag, "_order"}, nbad, 0);
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_resol"}, RESOL, 0);
        chk({tag, "_sg_rst"}, SG_RST, 1);
        chk({tag, "_vrstart"}, VRSTART, 0);
        chk({tag, "_req"}, FETCH_REQ, 0);
        chk({tag, "_line"}, FETCH_LINE, 0);
        chk({tag, "_fcnt"}, FRAME_CNT, 0);
        chk({tag, "_underrun"}, UNDERRUN, 0);
        chk({tag, "_busy"}, BUSY, 0);
    endtask

    initial begin
        int          first_vr, first_sg0, n_vr, n_sg, fc, nl;
        logic [1:0]  newres, newres2;

        tick(3);
        check_reset_vals("rst");
        DRST_X = 1'b1;
        tick(2);

        DISPON   = 1'b1;
        RESOL_IN = 2'b00;
        first_vr = -1;
        first_sg0 = -1;
        n_vr = 0;
        for (int k = 1; k <= 10; k++) begin
            tick();
            if (k == 1) chk("busy_on", BUSY, 1);
            if (VRSTART) begin
                n_vr++;
                if (first_vr < 0) first_vr = k;
            end
            if (!SG_RST && first_sg0 < 0) first_sg0 = k;
        end
        chk("vrstart_latency", first_vr, RST_CYC + 2);
        chk("vrstart_width", n_vr, 1);
        chk("sg_rst_release", first_sg0, RST_CYC + 2);
        chk("resol_vga", RESOL, 0);

        ack_en = 1'b1;
        got.delete();
        vsync_pulse();
        fc = 1;
        lines(480);
        tick(4);
        check_frame("vga1", 480, 2'd0);
        chk("vga1_fcnt", FRAME_CNT, fc % 16);
        chk("vga1_underrun", UNDERRUN, 0);

        got.delete();
        vsync_pulse();
        fc++;
        lines(200);
        newres   = 2'($urandom_range(1, 3));
        RESOL_IN = newres;
        tick(3);
        chk("resol_held_midframe", RESOL, 0);
        lines(280);
        tick(4);
        check_frame("vga2", 480, 2'd0);
        chk("vga2_fcnt", FRAME_CNT, fc % 16);

        DSP_VSYNC_X = 1'b0;
        n_sg = 0;
        n_vr = 0;
        for (int k = 1; k <= 12; k++) begin
            tick();
            if (k == 2) begin
                chk("resol_applied", RESOL, newres);
                chk("fcnt_cleared", FRAME_CNT, 0);
            end
            n_sg += int'(SG_RST);
            n_vr += int'(VRSTART);
        end
        chk("resel_sg_rst_cycles", n_sg, RST_CYC);
        chk("resel_vrstart_pulses", n_vr, 1);
        DSP_VSYNC_X = 1'b1;
        tick(8);

        got.delete();
        vsync_pulse();
        fc = 1;
        lines(vdo(newres));
        tick(4);
        check_frame("newres", vdo(newres), newres);
        chk("newres_fcnt", FRAME_CNT, fc % 16);
        chk("newres_underrun", UNDERRUN, 0);

        got.delete();
        vsync_pulse();
        fc++;
        lines(3);
        tick(2);
        ack_en  = 1'b0;
        ack_man = 1'b0;
        lines(1);
        chk("pend_req", FETCH_REQ, 1);
        chk("pend_line", FETCH_LINE, 4);
        DSP_preDE = 1'b1;
        tick(2);
        DSP_preDE = 1'b0;
        tick();
        ack_man = 1'b1;
        tick();
        ack_man = 1'b0;
        chk("coinc_req", FETCH_REQ, 1);
        chk("coinc_line", FETCH_LINE, 5);
        chk("coinc_underrun", UNDERRUN, 0);
        tick(5);
        lines(1);
        chk("ovr_underrun", UNDERRUN, 1);
        chk("ovr_line_kept", FETCH_LINE, 5);
        chk("ovr_req", FETCH_REQ, 1);
        ack_en = 1'b1;
        lines(3);
        chk("underrun_sticky", UNDERRUN, 1);

        DISPON = 1'b0;
        got.delete();
        lines(5);
        chk("off_still_fetching", got.size(), 5);
        chk("off_still_busy", BUSY, 1);
        ack_en = 1'b0;
        lines(1);
        DSP_VSYNC_X = 1'b0;
        tick(2);
        chk("off_busy", BUSY, 0);
        tick();
        fc++;
        chk("off_sg_rst", SG_RST, 1);
        chk("off_req_dropped", FETCH_REQ, 0);
        chk("off_fcnt", FRAME_CNT, fc % 16);
        DSP_VSYNC_X = 1'b1;
        tick(3);

        newres2  = 2'($urandom_range(0, 3));
        RESOL_IN = newres2;
        DISPON   = 1'b1;
        tick(10);
        chk("reon_resol", RESOL, newres2);
        chk("reon_underrun_clr", UNDERRUN, 0);
        chk("reon_fcnt", FRAME_CNT, 0);
        chk("reon_sg_rst", SG_RST, 0);
        vsync_pulse();
        chk("prerst_req", FETCH_REQ, 1);
        DRST_X = 1'b0;
        tick();
        check_reset_vals("midrst");
        DRST_X = 1'b1;
        DISPON = 1'b0;
        tick(2);

        RESOL_IN = 2'b00;
        DISPON   = 1'b1;
        ack_en   = 1'b1;
        tick(10);
        fc = 0;
        for (int f = 1; f <= 17; f++) begin
            got.delete();
            nl = $urandom_range(1, 4);
            vsync_pulse();
            fc++;
            lines(nl);
            tick(2);
            chk("wrap_fcnt", FRAME_CNT, fc % 16);
            check_frame("short", nl, 2'd0);
        end
        chk("wrap_underrun", UNDERRUN, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
